// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between the fetch and data ports of the core.
// One transaction in flight; fetch is forced after STARVE_MAX back-to-back data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    output logic                i_fault,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_wmask,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                d_err,
    output logic                d_stall,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_wmask,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_err
);
    localparam int MASK_W = DATA_W / 8;
    localparam int STRK_W = $clog2(STARVE_MAX + 1);
    localparam logic [STRK_W-1:0] STREAK_MAX = STRK_W'(STARVE_MAX);
    localparam logic [7:0]        TMO_LAST   = 8'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        r_state;
    logic              r_own_d;
    logic              r_we;
    logic [MASK_W-1:0] r_wmask;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRK_W-1:0] r_streak;
    logic [7:0]        r_tcnt;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_fault;
    logic              r_d_err;

    logic w_grant_i;
    logic w_grant_d;
    logic w_timeout;
    logic w_i_ack;
    logic w_d_ack;

    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == S_IDLE) begin
            if (i_req && d_req) begin
                w_grant_i = (r_streak == STREAK_MAX);
                w_grant_d = (r_streak != STREAK_MAX);
            end else begin
                w_grant_i = i_req;
                w_grant_d = d_req;
            end
        end
    end

    assign w_timeout = (r_tcnt == TMO_LAST);
    assign w_i_ack   = (r_state == S_RESP) && !r_own_d;
    assign w_d_ack   = (r_state == S_RESP) && r_own_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_own_d   <= 1'b0;
            r_we      <= 1'b0;
            r_wmask   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_streak  <= '0;
            r_tcnt    <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_fault <= 1'b0;
            r_d_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_i) begin
                        r_own_d  <= 1'b0;
                        r_we     <= 1'b0;
                        r_wmask  <= '0;
                        r_addr   <= i_addr;
                        r_wdata  <= '0;
                        r_streak <= '0;
                        r_state  <= S_ISSUE;
                    end else if (w_grant_d) begin
                        r_own_d <= 1'b1;
                        r_we    <= d_we;
                        r_wmask <= d_wmask;
                        r_addr  <= d_addr;
                        r_wdata <= d_wdata;
                        r_state <= S_ISSUE;
                        // Streak only counts data grants that made fetch wait.
                        if (!i_req) begin
                            r_streak <= '0;
                        end else if (r_streak != STREAK_MAX) begin
                            r_streak <= r_streak + STRK_W'(1);
                        end
                    end else begin
                        r_streak <= '0;
                    end
                end
                S_ISSUE: begin
                    if (m_gnt) begin
                        r_tcnt  <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_tcnt <= r_tcnt + 8'd1;
                    if (m_rvalid || w_timeout) begin
                        r_state <= S_RESP;
                        if (r_own_d) begin
                            r_d_rdata <= m_rvalid ? m_rdata : '0;
                            r_d_err   <= m_rvalid ? m_err : 1'b1;
                        end else begin
                            r_i_rdata <= m_rvalid ? m_rdata : '0;
                            r_i_fault <= m_rvalid ? m_err : 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_req   = (r_state == S_ISSUE);
    assign m_we    = r_we;
    assign m_wmask = r_wmask;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;

    assign i_ack   = w_i_ack;
    assign i_rdata = r_i_rdata;
    assign i_fault = r_i_fault;
    assign d_ack   = w_d_ack;
    assign d_rdata = r_d_rdata;
    assign d_err   = r_d_err;
    assign d_stall = d_req && !w_d_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: requesters push expected responses, a monitor pops them on each ack,
// and a request-level arbitration model checks every grant decision.
module tb_mem_port_arbiter;
    localparam int STARVE = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_fault;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_wmask = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        d_stall;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_wmask;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_err;

    int n_checks = 0;
    int n_fail = 0;
    exp_t iq[$];
    exp_t dq[$];
    logic grants[$];
    int force_gd = -1;
    int force_rd = -1;
    int stale_req = 0;
    int stale_done = 0;
    logic last_i = 1'b0;
    logic last_d = 1'b0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE), .TIMEOUT(8)) dut (
        .clk(clk), .reset(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_fault(i_fault),
        .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_wmask(m_wmask), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Memory contents: byte lanes hold addr[7:0]+lane; page E answers with error, page F never answers.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    function automatic exp_t exp_of(input logic [31:0] a);
        exp_t e;
        if (a[11:8] == 4'hF) begin
            e.rdata = '0;
            e.err   = 1'b1;
        end else begin
            e.rdata = mem_word(a);
            e.err   = (a[11:8] == 4'hE);
        end
        return e;
    endfunction

    task automatic fetch_txn(input logic [31:0] a, input int gap);
        int t;
        repeat (gap) @(posedge clk);
        #1;
        i_addr = a;
        i_req  = 1'b1;
        iq.push_back(exp_of(a));
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!i_ack && t < 300);
        chk("i_ack_seen", i_ack, 1);
        @(posedge clk);
        #1;
        i_req = 1'b0;
    endtask

    task automatic data_txn(input logic [31:0] a, input logic we, input logic [3:0] wm,
                            input logic [31:0] wd, input int gap);
        int t;
        repeat (gap) @(posedge clk);
        #1;
        d_addr  = a;
        d_we    = we;
        d_wmask = wm;
        d_wdata = wd;
        d_req   = 1'b1;
        dq.push_back(exp_of(a));
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!d_ack && t < 300);
        chk("d_ack_seen", d_ack, 1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_req"}, m_req, 0);
        chk({tag, "_m_we"}, m_we, 0);
        chk({tag, "_m_wmask"}, m_wmask, 0);
        chk({tag, "_m_addr"}, m_addr, 0);
        chk({tag, "_m_wdata"}, m_wdata, 0);
        chk({tag, "_i_ack"}, i_ack, 0);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_i_fault"}, i_fault, 0);
        chk({tag, "_d_ack"}, d_ack, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_d_err"}, d_err, 0);
        chk({tag, "_d_stall"}, d_stall, 0);
    endtask

    always @(posedge clk) begin
        last_i <= i_req;
        last_d <= d_req;
    end

    // Request-level arbitration model: data wins ties until STARVE data grants made fetch wait.
    initial begin
        int   streak;
        logic mreq_q;
        logic is_f;
        logic exp_f;
        streak = 0;
        mreq_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                streak = 0;
                mreq_q = 1'b0;
            end else begin
                if (m_req && !mreq_q) begin
                    is_f = m_addr[12];
                    grants.push_back(is_f);
                    exp_f = (last_i && last_d) ? (streak >= STARVE) : last_i;
                    chk("grant_sel", is_f, exp_f);
                    if (is_f) streak = 0;
                    else if (last_i) streak = (streak < STARVE) ? streak + 1 : STARVE;
                    else streak = 0;
                end else if (!last_i && !last_d) begin
                    streak = 0;
                end
                mreq_q = m_req;
            end
        end
    end

    // Response monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("ack_exclusive", i_ack && d_ack, 0);
                chk("d_stall", d_stall, d_req && !d_ack);
                if (i_ack) begin
                    chk("i_ack_pending", iq.size() != 0, 1);
                    if (iq.size() != 0) begin
                        e = iq.pop_front();
                        chk("i_rdata", i_rdata, e.rdata);
                        chk("i_fault", i_fault, e.err);
                    end
                end
                if (d_ack) begin
                    chk("d_ack_pending", dq.size() != 0, 1);
                    if (dq.size() != 0) begin
                        e = dq.pop_front();
                        chk("d_rdata", d_rdata, e.rdata);
                        chk("d_err", d_err, e.err);
                    end
                end
            end
        end
    end

    // Memory model.
    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        int gd;
        int rd;
        int t;
        m_gnt = 1'b0;
        m_rvalid = 1'b0;
        m_rdata = '0;
        m_err = 1'b0;
        forever begin
            @(negedge clk);
            if (stale_req != stale_done) begin
                m_rvalid = 1'b1;
                m_rdata  = 32'hDEADBEEF;
                m_err    = 1'b1;
                @(negedge clk);
                m_rvalid = 1'b0;
                stale_done++;
            end else if (m_req && rst_n) begin
                a  = m_addr;
                wd = m_wdata;
                if (a[12]) begin
                    chk("pay_i_addr", a, i_addr);
                    chk("pay_i_we", m_we, 0);
                    chk("pay_i_wmask", m_wmask, 0);
                    chk("pay_i_wdata", wd, 0);
                end else begin
                    chk("pay_d_addr", a, d_addr);
                    chk("pay_d_we", m_we, d_we);
                    chk("pay_d_wmask", m_wmask, d_wmask);
                    chk("pay_d_wdata", wd, d_wdata);
                end
                gd = (force_gd >= 0) ? force_gd : $urandom_range(0, 3);
                for (int k = 0; k < gd; k++) begin
                    @(negedge clk);
                    chk("mreq_held", m_req, 1);
                    chk("maddr_stable", m_addr, a);
                    chk("mwdata_stable", m_wdata, wd);
                end
                m_gnt = 1'b1;
                @(negedge clk);
                m_gnt = 1'b0;
                if (a[11:8] == 4'hF) begin
                    t = 1;
                    while (!(i_ack || d_ack) && rst_n && t < 40) begin
                        @(negedge clk);
                        t++;
                    end
                    if (rst_n) chk("timeout_wait_cycles", t, 9);
                end else begin
                    rd = (force_rd >= 0) ? force_rd : $urandom_range(0, 2);
                    repeat (rd) @(negedge clk);
                    m_rvalid = 1'b1;
                    m_rdata  = mem_word(a);
                    m_err    = (a[11:8] == 4'hE);
                    @(negedge clk);
                    m_rvalid = 1'b0;
                    m_rdata  = $urandom;
                    m_err    = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        int n;
        int t;

        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Single load, best-case memory timing.
        force_gd = 0;
        force_rd = 0;
        @(posedge clk);
        #1;
        d_we = 1'b0; d_wmask = '0; d_addr = 32'h10; d_wdata = '0; d_req = 1'b1;
        dq.push_back(exp_of(32'h10));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("load_m_req_c%0d", c), m_req, c == 1);
            chk($sformatf("load_d_ack_c%0d", c), d_ack, c == 3);
            chk($sformatf("load_d_stall_c%0d", c), d_stall, c != 3);
        end
        chk("load_d_rdata", d_rdata, 32'h13121110);
        chk("load_d_err", d_err, 0);
        @(posedge clk);
        #1 d_req = 1'b0;
        @(negedge clk);
        chk("load_ack_one_cycle", d_ack, 0);
        chk("load_idle_m_req", m_req, 0);

        // Store with the grant withheld so the payload must hold across cycles.
        force_gd = 2;
        force_rd = -1;
        data_txn(32'h20, 1'b1, 4'b0011, 32'hAABBCCDD, 0);

        // Continuous contention.
        force_gd = -1;
        grants.delete();
        fork
            for (int k = 0; k < 8; k++) data_txn(32'($urandom_range(0, 4095)), 1'b0, 4'h0, $urandom, 0);
            for (int k = 0; k < 2; k++) fetch_txn(32'h1000 | 32'($urandom_range(0, 4095)), 0);
        join
        pat = 10'b10_0001_0000;
        chk("contention_grants", grants.size(), 10);
        for (int k = 0; k < 10 && k < grants.size(); k++) begin
            chk($sformatf("contention_order_%0d", k), grants[k], pat[k]);
        end

        // Backpressure plus error response on a fetch.
        repeat (2) @(posedge clk);
        force_gd = 5;
        force_rd = 1;
        n = 0;
        fork
            fetch_txn(32'h1E40, 0);
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (m_req) n++;
                chk("bp_no_d_ack", d_ack, 0);
            end
        join
        chk("bp_m_req_cycles", n, 6);

        // Timeout on a data load.
        force_gd = 0;
        force_rd = -1;
        data_txn(32'h0F00, 1'b0, 4'h0, 32'h0, 0);
        @(negedge clk);
        chk("timeout_back_idle", m_req, 0);

        // Randomized traffic from both ports.
        force_gd = -1;
        fork
            for (int k = 0; k < 30; k++) begin
                logic we;
                we = 1'($urandom_range(0, 1));
                data_txn(32'($urandom_range(0, 4095)), we, we ? 4'($urandom) : 4'h0, $urandom,
                         $urandom_range(0, 3));
            end
            for (int k = 0; k < 30; k++) begin
                fetch_txn(32'h1000 | 32'($urandom_range(0, 4095)), $urandom_range(0, 3));
            end
        join

        // Reset while a fetch sits in WAIT.
        force_gd = 0;
        fetch_txn(32'h1100, 0);
        @(posedge clk);
        #1;
        i_addr = 32'h1F00;
        i_req  = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!m_req && t < 20);
        chk("rst_fetch_issued", m_req, 1);
        do begin @(negedge clk); t++; end while (m_req && t < 40);
        #1;
        rst_n = 1'b0;
        i_req = 1'b0;
        #1;
        chk_all_zero("rst_wait");
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        stale_req++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stale_no_i_ack", i_ack, 0);
            chk("stale_no_d_ack", d_ack, 0);
        end
        force_gd = -1;
        fetch_txn(32'h1234, 0);

        repeat (3) @(negedge clk);
        chk("iq_drained", iq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the RV32I core's instruction-fetch port and its data (load/store) port.
- Serialises requests with one transaction outstanding, and returns responses and errors to the owning requester.
- Generates the core's data_stall, data_err and inst_access_fault style signals.
- Sits between the core and the unified memory model or bus bridge.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; mask width is DATA_W/8
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced
- TIMEOUT, 255, cycles in WAIT without m_rvalid before an error response is generated; counter is 8 bits

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_ack
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word, valid with i_ack
- i_ack  out  1  one-cycle fetch completion pulse
- i_fault  out  1  fetch error, valid with i_ack
- d_req  in  1  data request; held with payload stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_wmask  in  DATA_W/8  byte write mask
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_ack
- d_ack  out  1  one-cycle data completion pulse
- d_err  out  1  data error, valid with d_ack
- d_stall  out  1  d_req & ~d_ack, combinational
- m_req  out  1  memory request; held until m_gnt
- m_we  out  1  memory write enable
- m_wmask  out  DATA_W/8  memory byte mask; all zeros on fetch
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_gnt  in  1  memory accepted request
- m_rvalid  in  1  response valid; at least one cycle after m_gnt
- m_rdata  in  DATA_W  response data
- m_err  in  1  response error, valid with m_rvalid

Behaviour:
- Reset: asserting reset low immediately clears all registered outputs to 0 and sets state to IDLE.
  - streak, timeout counter, owner and payload registers are cleared.
  - An in-flight memory transaction is abandoned; its response is not forwarded.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Sample i_req and d_req.
  - Only one asserted: grant it.
  - Both asserted: grant data unless streak==STARVE_MAX, in which case grant fetch.
  - On grant: latch owner and payload, go to ISSUE.
  - Fetch payload: m_we=0, m_wmask=0, m_wdata=0.
- ISSUE:
  - m_req=1 with latched payload.
  - m_gnt=1 -> WAIT and clear the timeout counter.
  - m_rvalid in ISSUE is ignored.
- WAIT:
  - m_req=0. The timeout counter increments each cycle.
  - m_rvalid=1 -> latch m_rdata and m_err, go to RESP.
  - Counter reaches TIMEOUT with no m_rvalid -> latch rdata=0 and err=1, go to RESP.
  - The memory must not respond after a timeout.
- RESP:
  - Owner's ack=1 for exactly one cycle; its rdata and err/fault are driven from the latched values.
  - The other requester's ack stays 0.
  - Next state is IDLE unconditionally. Requests are not sampled in RESP.
- rdata/err hold their last value after ack until the next RESP for that port. Store responses also return m_rdata on d_rdata.
- Streak counter:
  - Increments on each data grant made while i_req=1, saturating at STARVE_MAX.
  - Clears on a fetch grant, or in IDLE when i_req=0.
- Latency, best case (m_gnt in the first ISSUE cycle, m_rvalid in the first WAIT cycle):
  - Request sampled in IDLE at cycle 0 -> m_req at cycle 1 -> ack at cycle 3.
  - Next IDLE at cycle 4; peak throughput is one transaction per 4 cycles.
- Requester changing payload before ack: undefined; the latched payload is used.
- Requester dropping req before ack: the transaction still completes on the memory side, and an ack pulse is still produced.

Test Plan:
- Single load: d_req=1, d_addr=0x10, d_we=0; memory m_gnt immediate, m_rvalid next cycle, m_rdata=0x13121110.
  - Required: m_req at cycle 1, d_ack at cycle 3 with d_rdata=0x13121110 and d_err=0.
  - Required: d_stall=1 in cycles 0-2 and 0 in cycle 3.
- Store: d_we=1, d_wmask=4'b0011, d_addr=0x20, d_wdata=0xAABBCCDD.
  - Required: m_we=1, m_wmask=0011, m_addr=0x20 and m_wdata=0xAABBCCDD while m_req=1.
  - Required: one d_ack pulse.
- Contention, STARVE_MAX=4: i_req and d_req held continuously.
  - Required grant order: D,D,D,D,I,D,D,D,D,I; i_ack never blocked for more than 4 data transactions.
- Backpressure and error: m_gnt withheld 5 cycles, then m_rvalid with m_err=1 on a fetch.
  - Required: m_req held 6 cycles with a stable address, then i_ack=1 and i_fault=1.
  - Required: d_ack stays 0.
- Timeout: m_gnt given, m_rvalid never asserted, TIMEOUT=8.
  - Required: 8 WAIT cycles, then d_ack=1, d_err=1, d_rdata=0, then return to IDLE.
- Reset mid-WAIT: pull reset low during WAIT.
  - Required: all outputs 0 immediately.
  - Required: after release, a stale m_rvalid produces no ack, and a fresh i_req completes normally.
